// File: rtl/bcd_serial_addsub_if.sv
// rtl/bcd_serial_addsub_if.sv - request/response bundle for the serial BCD adder/subtractor
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   op_a;
  logic [4*DIGITS-1:0]   op_b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, cout, err
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, cout, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - packed-BCD add/subtract, one digit per clock, LSD first
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_addsub_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_sub;
  logic             r_carry;
  logic             r_err_in;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_err;

  logic             w_err_any;
  logic [3:0]       w_b_adj;
  logic [4:0]       w_sum;
  logic             w_carry_nxt;
  logic [3:0]       w_digit;
  logic [W-1:0]     w_digit_ext;
  logic             w_last;

  always_comb begin
    w_err_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.op_a[4*i +: 4] > 4'd9 || bus.op_b[4*i +: 4] > 4'd9) begin
        w_err_any = 1'b1;
      end
    end
  end

  // Operands shift right each digit, so the active digit is always bits [3:0].
  assign w_b_adj     = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
  assign w_sum       = {1'b0, r_a[3:0]} + {1'b0, w_b_adj} + {4'd0, r_carry};
  assign w_carry_nxt = (w_sum > 5'd9);
  assign w_digit     = w_carry_nxt ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
  assign w_digit_ext = W'(w_digit) << (W - 4);
  // Index reaches DIGITS on the extra cycle that publishes the result.
  assign w_last      = (r_idx == IDX_W'(DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_err_in <= 1'b0;
      r_idx    <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_sub    <= bus.sub;
            r_carry  <= bus.sub;
            r_err_in <= w_err_any;
            r_idx    <= '0;
            r_work   <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_result <= r_err_in ? '0 : r_work;
            r_cout   <= r_err_in ? 1'b0 : r_carry;
            r_err    <= r_err_in;
            r_state  <= S_DONE;
          end else begin
            r_work  <= (r_work >> 4) | w_digit_ext;
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_carry_nxt;
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - scoreboard bench for bcd_serial_addsub, DIGITS=4
module tb_bcd_serial_addsub;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   acc_cyc;
  int   rel_cyc;
  int   prev_rel;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        e;
  } exp_t;

  exp_t q[$];

  bcd_serial_addsub_if #(.DIGITS(D)) bus ();

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int          m;
    m = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t x;
    int   ia, ib, t;
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    ia = bcd2int(a);
    ib = bcd2int(b);
    if (bad) begin
      x.res = 16'h0000; x.c = 1'b0; x.e = 1'b1;
    end else if (!s) begin
      t = ia + ib;
      x.res = int2bcd(t % 10000); x.c = (t >= 10000); x.e = 1'b0;
    end else begin
      if (ia >= ib) begin
        x.res = int2bcd(ia - ib); x.c = 1'b1;
      end else begin
        x.res = int2bcd(10000 + ia - ib); x.c = 1'b0;
      end
      x.e = 1'b0;
    end
    return x;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int stall, input bit hold);
    int   n;
    exp_t x;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    q.push_back(model(a, b, s));
    if (hold) begin
      bus.op_a = 16'h9999;
      bus.op_b = 16'h9999;
      bus.sub  = 1'b0;
    end else begin
      bus.in_valid = 1'b0;
    end
    n = 0;
    while (!bus.out_valid && n < 50) begin
      if (hold) check("in_ready_run", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(D + 1));
    check("queue_nonempty", 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      x = q.pop_front();
      check("result", 32'(bus.result), 32'(x.res));
      check("cout", 32'(bus.cout), 32'(x.c));
      check("err", 32'(bus.err), 32'(x.e));
      check("in_ready_done", 32'(bus.in_ready), 32'd0);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_result", 32'(bus.result), 32'(x.res));
        check("stall_cout", 32'(bus.cout), 32'(x.c));
        check("stall_err", 32'(bus.err), 32'(x.e));
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rel_cyc = cyc;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b0, 0, 1'b0);
    run_op(16'h5000, 16'h1234, 1'b1, 0, 1'b0);
    run_op(16'h0123, 16'h0456, 1'b1, 0, 1'b0);
    run_op(16'h4321, 16'h4321, 1'b1, 0, 1'b0);
    run_op(16'h12A4, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0042, 16'h0037, 1'b0, 3, 1'b1);
    prev_rel = rel_cyc;
    run_op(16'h2468, 16'h1357, 1'b1, 0, 1'b0);
    check("accept_after_release", 32'(acc_cyc), 32'(prev_rel + 1));

    bus.op_a     = 16'h1234;
    bus.op_b     = 16'h1111;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Multi-digit packed-BCD adder/subtractor. Processes one decimal digit per clock, LSD first, with a registered decimal carry.
- Sits directly upstream of the single-digit BCD/excess-3 add stage in the arithmetic path.
- Accepts full-width operands over a valid/ready handshake, runs the per-digit add-and-correct sequence, and returns a packed BCD result with carry/borrow and an operand-error flag.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); data width is 4*DIGITS.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
op_a  input  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]
op_b  input  4*DIGITS  packed BCD operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  4*DIGITS  packed BCD result
cout  output  1  add: decimal carry out; sub: 1 = no borrow (A>=B)
err  output  1  some operand digit was >9 at accept

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1; out_valid=0; result=0; cout=0; err=0; digit index=0; carry=0. Reset mid-operation abandons the operation, with no output.
- States and transitions:
  - IDLE -> RUN on in_valid&&in_ready.
  - RUN -> DONE after digit DIGITS-1 is processed.
  - DONE -> IDLE on out_ready.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- No new request is accepted in the cycle a result is released; the earliest next accept is the cycle after IDLE is re-entered.
- Accept edge:
  - Register op_a, op_b, sub; index=0; carry=sub.
  - err_reg = OR over all 2*DIGITS digits of (digit>9).
- RUN, per cycle, on digit i=index:
  - b' = sub ? (9 - b_i) : b_i, where 9 - b_i is the nines complement.
  - s = a_i + b' + carry, 5-bit, range 0..19.
  - If s>9: digit_i = (s+6)[3:0] and carry=1. Else digit_i = s[3:0] and carry=0.
  - Write digit_i into the result register; index++.
- Latency: out_valid rises exactly DIGITS+1 clock edges after the accept edge; for DIGITS=4, the 5th edge.
- Entering DONE:
  - cout = final carry.
  - If err_reg: result forced to all zeros and cout=0; err=1.
  - Else err=0.
- Subtraction uses ten's complement. If A<B, result is the ten's complement of B-A and cout=0.
- result, cout and err hold stable throughout DONE and remain at their last values in IDLE, until overwritten at the next DONE entry.
- out_ready low while in DONE stalls indefinitely; outputs do not change.
- op_a, op_b and sub are sampled only at the accept edge; later changes are ignored.
- in_valid asserted in RUN or DONE is not accepted. The requester must hold it until in_ready.

Test Plan:
- Add, DIGITS=4: A=0x1234, B=0x5678, sub=0 -> result=0x6912, cout=0, err=0; out_valid exactly 5 edges after accept.
- Add wrap: A=0x9999, B=0x0001 -> result=0x0000, cout=1. Also A=0x9999, B=0x9999 -> result=0x9998, cout=1.
- Subtract: A=0x5000, B=0x1234, sub=1 -> 0x3766, cout=1. A=0x0123, B=0x0456, sub=1 -> 0x9667, cout=0. A=B=0x4321, sub=1 -> 0x0000, cout=1.
- Invalid digit: A=0x12A4, B=0x0001 -> err=1, result=0x0000, cout=0; the next valid request clears err.
- Handshake:
  - in_valid held high during RUN is not accepted; in_ready=0 in RUN and DONE.
  - out_ready low for 3 cycles in DONE -> outputs stable, out_valid held.
  - Release -> IDLE; a new accept occurs the following cycle.
- Reset mid-RUN: assert rst_n=0 at index 2 -> all outputs at reset values immediately (asynchronously). After release, a fresh request 0x0001+0x0002 -> 0x0003, with correct latency.
